// File: rtl/peripheral_uart_fifo_if.sv
// J1 I/O bus slot as seen by a memory-mapped peripheral.
interface peripheral_uart_fifo_if;
    logic        cs;
    logic [3:0]  addr;
    logic        rd;
    logic        wr;
    logic [15:0] d_in;
    logic [15:0] d_out;

    modport master (output cs, addr, rd, wr, d_in, input d_out);
    modport slave  (input cs, addr, rd, wr, d_in, output d_out);
endinterface

// File: rtl/peripheral_uart_fifo.sv
// FIFO-buffered 8N1 UART peripheral on the J1 I/O bus: TX/RX FIFOs, runtime baud divisor,
// sticky error flags and a level IRQ.
module peripheral_uart_fifo_buf #(
    parameter int AW = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty,
    output logic       push_ok
);
    localparam logic [AW:0] DEPTH_V = {1'b1, {AW{1'b0}}};

    logic [7:0]    mem_r [2**AW];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          pop_ok_s;

    assign full     = (count_r == DEPTH_V);
    assign empty    = (count_r == '0);
    assign pop_ok_s = pop & ~empty;
    // A pop frees the slot the same cycle, so push into a full FIFO succeeds when paired with a pop.
    assign push_ok  = push & (~full | pop_ok_s);
    assign rdata    = mem_r[rd_ptr_r];

    // Storage write port
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and occupancy count
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_ok, pop_ok_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

module peripheral_uart_fifo #(
    parameter int FIFO_AW     = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 26
) (
    input  logic                   clk,
    input  logic                   rst,
    peripheral_uart_fifo_if.slave  bus,
    output logic                   uart_tx,
    input  logic                   uart_rxd,
    output logic                   irq
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_START = 2'd1, ST_DATA = 2'd2, ST_STOP = 2'd3} uart_state_e;

    localparam logic [3:0]       ADDR_DATA   = 4'h0;
    localparam logic [3:0]       ADDR_STATUS = 4'h2;
    localparam logic [3:0]       ADDR_CTRL   = 4'h4;
    localparam logic [3:0]       ADDR_BAUD   = 4'h6;
    localparam logic [DIV_W-1:0] DIV_RESET   = DIV_W'(DEFAULT_DIV);

    logic             rd_s, wr_s, tick_s, w1c_s;
    logic [2:0]       ctrl_r;
    logic [DIV_W-1:0] baud_r, tick_cnt_r;
    logic             rx_overrun_r, frame_err_r, tx_overflow_r, irq_r;
    logic [15:0]      d_out_r, rdata_s;
    logic [7:0]       status_s;
    logic             tx_busy_s;

    logic             tx_push_s, tx_pop_s, tx_full_s, tx_empty_s, tx_push_ok_s;
    logic [7:0]       tx_rdata_s;
    logic             rx_push_s, rx_pop_s, rx_full_s, rx_empty_s, rx_push_ok_s;
    logic [7:0]       rx_rdata_s;

    uart_state_e      tx_state_r, rx_state_r;
    logic [3:0]       tx_sub_r, rx_sub_r;
    logic [2:0]       tx_bit_r, rx_bit_r;
    logic [7:0]       tx_shift_r, rx_shift_r;
    logic             tx_line_r;
    logic             rx_sync1_r, rx_sync2_r, rx_prev_r, rx_stop_s;

    assign rd_s      = bus.cs & bus.rd;
    assign wr_s      = bus.cs & bus.wr;
    assign w1c_s     = wr_s & (bus.addr == ADDR_STATUS);
    assign tick_s    = (tick_cnt_r == baud_r);
    assign tx_push_s = wr_s & (bus.addr == ADDR_DATA);
    assign rx_pop_s  = rd_s & (bus.addr == ADDR_DATA);
    // The next byte is taken either from IDLE or on the last tick of STOP, giving gapless frames.
    assign tx_pop_s  = tick_s & ~tx_empty_s &
                       ((tx_state_r == ST_IDLE) | ((tx_state_r == ST_STOP) & (tx_sub_r == 4'd15)));
    assign rx_stop_s = (rx_state_r == ST_STOP) & tick_s & (rx_sub_r == 4'd15);
    assign rx_push_s = rx_stop_s & rx_sync2_r;
    assign tx_busy_s = (tx_state_r != ST_IDLE) | ~tx_empty_s;
    assign status_s  = {tx_overflow_r, tx_busy_s, frame_err_r, rx_overrun_r,
                        rx_full_s, ~rx_empty_s, tx_empty_s, tx_full_s};

    assign bus.d_out = d_out_r;
    assign uart_tx   = tx_line_r;
    assign irq       = irq_r;

    peripheral_uart_fifo_buf #(.AW(FIFO_AW)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push_s), .pop(tx_pop_s), .wdata(bus.d_in[7:0]),
        .rdata(tx_rdata_s), .full(tx_full_s), .empty(tx_empty_s), .push_ok(tx_push_ok_s)
    );

    peripheral_uart_fifo_buf #(.AW(FIFO_AW)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push_s), .pop(rx_pop_s), .wdata(rx_shift_r),
        .rdata(rx_rdata_s), .full(rx_full_s), .empty(rx_empty_s), .push_ok(rx_push_ok_s)
    );

    // Read data mux; unmapped addresses read zero
    always_comb begin
        rdata_s = 16'h0000;
        case (bus.addr)
            ADDR_DATA: begin
                if (!rx_empty_s) rdata_s = {8'h00, rx_rdata_s};
                else             rdata_s = 16'h0000;
            end
            ADDR_STATUS: rdata_s = {8'h00, status_s};
            ADDR_CTRL:   rdata_s = {13'h0000, ctrl_r};
            ADDR_BAUD:   rdata_s = 16'(baud_r);
            default:     rdata_s = 16'h0000;
        endcase
    end

    // Register file, sticky flags (set beats clear), read data and IRQ
    always_ff @(posedge clk) begin
        if (rst) begin
            d_out_r       <= 16'h0000;
            ctrl_r        <= 3'b000;
            baud_r        <= DIV_RESET;
            rx_overrun_r  <= 1'b0;
            frame_err_r   <= 1'b0;
            tx_overflow_r <= 1'b0;
            irq_r         <= 1'b0;
        end else begin
            if (rd_s) d_out_r <= rdata_s;
            if (wr_s && bus.addr == ADDR_CTRL) ctrl_r <= bus.d_in[2:0];
            if (wr_s && bus.addr == ADDR_BAUD) baud_r <= bus.d_in[DIV_W-1:0];
            rx_overrun_r  <= (rx_push_s & ~rx_push_ok_s) | (rx_overrun_r & ~(w1c_s & bus.d_in[4]));
            frame_err_r   <= (rx_stop_s & ~rx_sync2_r) | (frame_err_r & ~(w1c_s & bus.d_in[5]));
            tx_overflow_r <= (tx_push_s & ~tx_push_ok_s) | (tx_overflow_r & ~(w1c_s & bus.d_in[7]));
            irq_r <= (ctrl_r[0] & ~rx_empty_s) |
                     (ctrl_r[1] & tx_empty_s & (tx_state_r == ST_IDLE)) |
                     (ctrl_r[2] & (rx_overrun_r | frame_err_r | tx_overflow_r));
        end
    end

    // Baud tick counter: counts 0..baud_r, restarted by a BAUD write
    always_ff @(posedge clk) begin
        if (rst || (wr_s && bus.addr == ADDR_BAUD)) tick_cnt_r <= '0;
        else if (tick_s)                            tick_cnt_r <= '0;
        else                                        tick_cnt_r <= tick_cnt_r + 1'b1;
    end

    // Transmit FSM, 16 ticks per bit
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_r <= ST_IDLE;
            tx_sub_r   <= 4'd0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            tx_line_r  <= 1'b1;
        end else begin
            case (tx_state_r)
                ST_IDLE: begin
                    tx_line_r <= 1'b1;
                    if (tx_pop_s) begin
                        tx_shift_r <= tx_rdata_s;
                        tx_state_r <= ST_START;
                        tx_line_r  <= 1'b0;
                        tx_sub_r   <= 4'd0;
                    end
                end
                ST_START: if (tick_s) begin
                    if (tx_sub_r == 4'd15) begin
                        tx_state_r <= ST_DATA;
                        tx_line_r  <= tx_shift_r[0];
                        tx_sub_r   <= 4'd0;
                        tx_bit_r   <= 3'd0;
                    end else tx_sub_r <= tx_sub_r + 4'd1;
                end
                ST_DATA: if (tick_s) begin
                    if (tx_sub_r == 4'd15) begin
                        tx_sub_r <= 4'd0;
                        if (tx_bit_r == 3'd7) begin
                            tx_state_r <= ST_STOP;
                            tx_line_r  <= 1'b1;
                        end else begin
                            tx_bit_r   <= tx_bit_r + 3'd1;
                            tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                            tx_line_r  <= tx_shift_r[1];
                        end
                    end else tx_sub_r <= tx_sub_r + 4'd1;
                end
                ST_STOP: if (tick_s) begin
                    if (tx_sub_r == 4'd15) begin
                        tx_sub_r <= 4'd0;
                        if (tx_pop_s) begin
                            tx_shift_r <= tx_rdata_s;
                            tx_state_r <= ST_START;
                            tx_line_r  <= 1'b0;
                        end else tx_state_r <= ST_IDLE;
                    end else tx_sub_r <= tx_sub_r + 4'd1;
                end
                default: begin
                    tx_state_r <= ST_IDLE;
                    tx_line_r  <= 1'b1;
                end
            endcase
        end
    end

    // Two-flop synchroniser plus previous-sample flop for start-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync1_r <= 1'b1;
            rx_sync2_r <= 1'b1;
            rx_prev_r  <= 1'b1;
        end else begin
            rx_sync1_r <= uart_rxd;
            rx_sync2_r <= rx_sync1_r;
            rx_prev_r  <= rx_sync2_r;
        end
    end

    // Receive FSM: half-bit start check, then mid-bit sampling every 16 ticks
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_r <= ST_IDLE;
            rx_sub_r   <= 4'd0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
        end else begin
            case (rx_state_r)
                ST_IDLE: if (rx_prev_r && !rx_sync2_r) begin
                    rx_state_r <= ST_START;
                    rx_sub_r   <= 4'd0;
                end
                ST_START: if (tick_s) begin
                    if (rx_sub_r == 4'd7) begin
                        rx_sub_r <= 4'd0;
                        rx_bit_r <= 3'd0;
                        rx_state_r <= rx_sync2_r ? ST_IDLE : ST_DATA;
                    end else rx_sub_r <= rx_sub_r + 4'd1;
                end
                ST_DATA: if (tick_s) begin
                    if (rx_sub_r == 4'd15) begin
                        rx_sub_r   <= 4'd0;
                        rx_shift_r <= {rx_sync2_r, rx_shift_r[7:1]};
                        if (rx_bit_r == 3'd7) rx_state_r <= ST_STOP;
                        else                  rx_bit_r   <= rx_bit_r + 3'd1;
                    end else rx_sub_r <= rx_sub_r + 4'd1;
                end
                ST_STOP: if (tick_s) begin
                    if (rx_sub_r == 4'd15) begin
                        rx_sub_r   <= 4'd0;
                        rx_state_r <= ST_IDLE;
                    end else rx_sub_r <= rx_sub_r + 4'd1;
                end
                default: rx_state_r <= ST_IDLE;
            endcase
        end
    end
endmodule
